// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter (instruction fetch / data) in front of a single
// memory with combinational read and synchronous write; one access per 2 cycles.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic          i_resp_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_valid,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  input  logic [DW-1:0] mem_RD
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_last_grant;  // 0 = instruction port, 1 = data port
  logic          r_winner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_i_resp_valid;
  logic          r_d_resp_valid;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_grant_i;
  logic          w_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_d = d_valid && (!i_valid || !r_last_grant);
        w_grant_i = i_valid && (!d_valid || r_last_grant);
        if (w_grant_i || w_grant_d) w_next_state = ACCESS;
      end
      ACCESS:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign i_ready      = w_grant_i;
  assign d_ready      = w_grant_d;
  assign mem_we       = (r_state == ACCESS) && r_we;
  assign mem_A        = r_addr;
  assign mem_WD       = r_wdata;
  assign i_resp_valid = r_i_resp_valid;
  assign d_resp_valid = r_d_resp_valid;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;

  // Fetch requests carry no write data, so the write-data register is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant   <= 1'b0;
      r_winner       <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
    end else begin
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_grant_d) begin
          r_winner     <= 1'b1;
          r_we         <= d_we;
          r_addr       <= d_addr;
          r_wdata      <= d_wdata;
          r_last_grant <= 1'b1;
        end else if (w_grant_i) begin
          r_winner     <= 1'b0;
          r_we         <= 1'b0;
          r_addr       <= i_addr;
          r_wdata      <= '0;
          r_last_grant <= 1'b0;
        end
      end else if (r_winner) begin
        r_d_resp_valid <= 1'b1;
        r_d_rdata      <= r_we ? '0 : mem_RD;
      end else begin
        r_i_resp_valid <= 1'b1;
        r_i_rdata      <= mem_RD;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model of the arbiter and its memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready;
  logic          i_resp_valid;
  logic [DW-1:0] i_rdata;
  logic          d_valid = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic          d_resp_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic [DW-1:0] mem_RD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  function automatic logic [31:0] init_word(input int k);
    if (k == 4)  return 32'h1234;
    if (k == 16) return 32'h5555;
    return (32'(k) * 32'h9E3779B1) ^ 32'h0000A5A5;
  endfunction

  // Memory attached to the DUT: combinational read, synchronous write.
  logic [DW-1:0] ram [0:255];
  logic          ram_ready = 1'b0;
  assign mem_RD = ram[mem_A[7:0]];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_A[7:0]] <= mem_WD;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access in flight at a time, it takes the
  // cycle after acceptance, and its response appears the cycle after that.
  logic [DW-1:0] gold [0:255];
  logic          model_ready = 1'b0;
  logic          m_busy, m_port_d, m_we, m_last_d, m_ri, m_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_irdata, m_drdata;
  logic          n_busy, n_port_d, n_we, n_last_d, n_ri, n_rd, n_wr;
  logic [AW-1:0] n_addr;
  logic [DW-1:0] n_wdata, n_irdata, n_drdata;
  logic          e_ir, e_dr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_A", mem_A, 0);
      chk("rst_mem_WD", mem_WD, 0);
      chk("rst_i_resp_valid", 32'(i_resp_valid), 0);
      chk("rst_d_resp_valid", 32'(d_resp_valid), 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      n_wr <= 1'b0;
    end else if (model_ready) begin
      e_ir = !m_busy && i_valid && (!d_valid || m_last_d);
      e_dr = !m_busy && d_valid && (!i_valid || !m_last_d);
      chk("i_ready", 32'(i_ready), 32'(e_ir));
      chk("d_ready", 32'(d_ready), 32'(e_dr));
      chk("mem_we", 32'(mem_we), 32'(m_busy && m_we));
      chk("mem_A", mem_A, m_addr);
      chk("mem_WD", mem_WD, m_wdata);
      chk("i_resp_valid", 32'(i_resp_valid), 32'(m_ri));
      chk("d_resp_valid", 32'(d_resp_valid), 32'(m_rd));
      chk("i_rdata", i_rdata, m_irdata);
      chk("d_rdata", d_rdata, m_drdata);
      n_busy <= 1'b0;  n_port_d <= m_port_d; n_we <= m_we; n_last_d <= m_last_d;
      n_ri <= 1'b0;    n_rd <= 1'b0;         n_wr <= 1'b0;
      n_addr <= m_addr; n_wdata <= m_wdata; n_irdata <= m_irdata; n_drdata <= m_drdata;
      if (m_busy) begin
        if (m_port_d) begin
          n_rd     <= 1'b1;
          n_drdata <= m_we ? '0 : gold[m_addr[7:0]];
          n_wr     <= m_we;
        end else begin
          n_ri     <= 1'b1;
          n_irdata <= gold[m_addr[7:0]];
        end
      end else if (e_dr) begin
        n_busy <= 1'b1; n_port_d <= 1'b1; n_we <= d_we; n_addr <= d_addr;
        n_wdata <= d_wdata; n_last_d <= 1'b1;
      end else if (e_ir) begin
        n_busy <= 1'b1; n_port_d <= 1'b0; n_we <= 1'b0; n_addr <= i_addr;
        n_wdata <= '0; n_last_d <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!model_ready) begin
      for (int k = 0; k < 256; k++) gold[k] <= init_word(k);
      model_ready <= 1'b1;
    end
    if (rst || !model_ready) begin
      m_busy <= 1'b0; m_port_d <= 1'b0; m_we <= 1'b0; m_last_d <= 1'b0;
      m_ri <= 1'b0; m_rd <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_irdata <= '0; m_drdata <= '0;
    end else begin
      if (n_wr) gold[m_addr[7:0]] <= m_wdata;
      m_busy <= n_busy; m_port_d <= n_port_d; m_we <= n_we; m_last_d <= n_last_d;
      m_ri <= n_ri; m_rd <= n_rd; m_addr <= n_addr; m_wdata <= n_wdata;
      m_irdata <= n_irdata; m_drdata <= n_drdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  int exp_g[4] = '{1, 0, 1, 0};
  int n_resp, n_rdy, n_coinc;
  logic acc_i, acc_d;

  initial begin
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_i_rdata", i_rdata, 0);
    tick();
    rst = 1'b0;

    // Single instruction read of address 4.
    i_valid = 1'b1; i_addr = 32'h4;
    @(negedge clk); chk("t1_i_ready", 32'(i_ready), 1);
    tick(); i_valid = 1'b0;
    @(negedge clk); chk("t1_i_ready_low", 32'(i_ready), 0); chk("t1_mem_A", mem_A, 32'h4);
    tick();
    @(negedge clk); chk("t1_i_resp", 32'(i_resp_valid), 1); chk("t1_i_rdata", i_rdata, 32'h1234);
    tick();
    @(negedge clk); chk("t1_i_resp_pulse", 32'(i_resp_valid), 0); chk("t1_i_rdata_hold", i_rdata, 32'h1234);

    // Data write then back-to-back read of address 8.
    tick();
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hF001;
    @(negedge clk); chk("t2_d_ready", 32'(d_ready), 1);
    tick(); d_valid = 1'b0;
    @(negedge clk); chk("t2_mem_we", 32'(mem_we), 1);
    tick(); d_valid = 1'b1; d_we = 1'b0;
    @(negedge clk);
    chk("t2_mem_we_drop", 32'(mem_we), 0); chk("t2_wr_resp", 32'(d_resp_valid), 1);
    chk("t2_wr_rdata", d_rdata, 0); chk("t2_b2b_ready", 32'(d_ready), 1);
    chk("t2_ram8", ram[8], 32'hF001);
    tick(); d_valid = 1'b0;
    @(negedge clk); chk("t2_rd_no_we", 32'(mem_we), 0);
    tick();
    @(negedge clk); chk("t2_rd_resp", 32'(d_resp_valid), 1); chk("t2_rd_rdata", d_rdata, 32'hF001);

    // Both ports requesting continuously straight out of reset.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    i_valid = 1'b1; i_addr = 32'($urandom_range(0, 63));
    d_valid = 1'b1; d_we = 1'b0; d_addr = 32'($urandom_range(0, 63));
    grants.delete(); n_resp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ready) grants.push_back(1);
      if (i_ready) grants.push_back(0);
      if (i_resp_valid || d_resp_valid) n_resp++;
      acc_i = i_valid && i_ready; acc_d = d_valid && d_ready;
      tick();
      if (acc_i) i_addr = 32'($urandom_range(0, 63));
      if (acc_d) d_addr = 32'($urandom_range(0, 63));
    end
    i_valid = 1'b0; d_valid = 1'b0;
    chk("t3_grant_count", 32'(grants.size()), 4);
    for (int g = 0; g < 4 && g < grants.size(); g++) chk("t3_grant_order", 32'(grants[g]), 32'(exp_g[g]));
    chk("t3_resp_count", 32'(n_resp), 3);
    repeat (3) tick();

    // Reset in the middle of a data write to 0x10.
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hAAAA;
    @(negedge clk); chk("t4_d_ready", 32'(d_ready), 1);
    tick(); d_valid = 1'b0;
    @(negedge clk); chk("t4_mem_we", 32'(mem_we), 1);
    #2 rst = 1'b1;
    #1 chk("t4_we_async_drop", 32'(mem_we), 0);
    tick(); rst = 1'b0;
    @(negedge clk); chk("t4_no_resp", 32'(d_resp_valid), 0);
    tick();
    @(negedge clk); chk("t4_no_resp2", 32'(d_resp_valid), 0); chk("t4_ram16", ram[16], 32'h5555);

    // Instruction port alone, held valid.
    tick();
    i_valid = 1'b1; i_addr = 32'($urandom_range(0, 63));
    n_rdy = 0; n_resp = 0; n_coinc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_ready) n_rdy++;
      if (i_resp_valid) n_resp++;
      if (i_resp_valid && i_ready) n_coinc++;
      acc_i = i_ready;
      tick();
      if (acc_i) i_addr = 32'($urandom_range(0, 63));
    end
    i_valid = 1'b0;
    chk("t5_ready_count", 32'(n_rdy), 4);
    chk("t5_resp_count", 32'(n_resp), 3);
    chk("t5_resp_with_ready", 32'(n_coinc), 3);
    repeat (2) tick();

    // Randomized traffic with occasional resets; requesters hold until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc_i = i_valid && i_ready && !rst;
      acc_d = d_valid && d_ready && !rst;
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if (!i_valid || acc_i) begin
        i_valid = ($urandom_range(0, 2) != 0);
        i_addr  = 32'($urandom_range(0, 63));
      end
      if (!d_valid || acc_d) begin
        d_valid = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
    end
    rst = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
